// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_reader
// Description : SPI flash read sequencer. Optionally wakes the flash (0xAB),
//               then sends READ (0x03) and a 24-bit address. Received bytes
//               are streamed out on a valid/ready byte interface.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_reader #(
    parameter int CLKDIV      = 2,
    parameter int WAKE        = 1,
    parameter int WAKE_CYCLES = 144
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] count,
    input  logic        abort,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    input  logic        spi_miso
);

    localparam int                 c_div_w    = $clog2(CLKDIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLKDIV - 1);
    localparam logic [15:0]        c_gap_last = 16'(WAKE_CYCLES - 1);
    localparam logic [7:0]         c_cmd_wake = 8'hAB;
    localparam logic [7:0]         c_cmd_read = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAKE_CMD = 3'd1,
        S_WAKE_GAP = 3'd2,
        S_CMD      = 3'd3,
        S_ADDR     = 3'd4,
        S_DATA     = 3'd5,
        S_HOLD     = 3'd6,
        S_FINISH   = 3'd7
    } state_t;

    state_t               r_state;
    logic [c_div_w-1:0]   r_div;    // clk count within the current SCK half-period
    logic [4:0]           r_bits;   // bits completed in the current frame
    logic [15:0]          r_gap;    // clks spent with CS high after the wake command
    logic [31:0]          r_shift;  // outgoing bits, MSB is on the wire
    logic [6:0]           r_rx;     // first seven bits of the incoming byte
    logic [23:0]          r_addr;
    logic [15:0]          r_left;   // bytes not yet accepted by the consumer

    logic w_phase_end;

    assign w_phase_end = (r_div == c_div_last);
    assign spi_mosi    = r_shift[31];

    // Sequencer: state, SPI pin timing, byte capture and handshake outputs
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bits    <= '0;
            r_gap     <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_addr    <= '0;
            r_left    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spi_sck   <= 1'b0;
            spi_cs_n  <= 1'b1;
        end else if (abort && (r_state != S_IDLE)) begin
            // Drop everything, including a partially received byte
            r_state   <= S_IDLE;
            r_shift   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spi_sck   <= 1'b0;
            spi_cs_n  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= addr;
                        r_left  <= count;
                        busy    <= 1'b1;
                        r_div   <= '0;
                        r_bits  <= '0;
                        spi_sck <= 1'b0;
                        if (count == 16'd0) begin
                            // Nothing to read: CS never falls
                            r_state <= S_FINISH;
                        end else begin
                            spi_cs_n <= 1'b0;
                            if (WAKE != 0) begin
                                r_shift <= {c_cmd_wake, 24'h000000};
                                r_state <= S_WAKE_CMD;
                            end else begin
                                r_shift <= {c_cmd_read, addr};
                                r_state <= S_CMD;
                            end
                        end
                    end
                end

                S_WAKE_GAP: begin
                    if (r_gap == c_gap_last) begin
                        spi_cs_n <= 1'b0;
                        r_shift  <= {c_cmd_read, r_addr};
                        r_div    <= '0;
                        r_bits   <= '0;
                        r_state  <= S_CMD;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end

                S_WAKE_CMD, S_CMD, S_ADDR, S_DATA: begin
                    if (!w_phase_end) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div   <= '0;
                        spi_sck <= ~spi_sck;
                        if (spi_sck) begin
                            // End of the high phase: sample MISO, present next MOSI bit
                            r_rx    <= {r_rx[5:0], spi_miso};
                            r_shift <= {r_shift[30:0], 1'b0};
                            r_bits  <= r_bits + 5'd1;
                            case (r_state)
                                S_WAKE_CMD: begin
                                    if (r_bits == 5'd7) begin
                                        spi_cs_n <= 1'b1;
                                        r_gap    <= '0;
                                        r_state  <= S_WAKE_GAP;
                                    end
                                end
                                S_CMD: begin
                                    if (r_bits == 5'd7) begin
                                        r_state <= S_ADDR;
                                    end
                                end
                                S_ADDR: begin
                                    if (r_bits == 5'd31) begin
                                        r_bits  <= '0;
                                        r_state <= S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    if (r_bits == 5'd7) begin
                                        out_data  <= {r_rx, spi_miso};
                                        out_valid <= 1'b1;
                                        r_state   <= S_HOLD;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                S_HOLD: begin
                    // SCK parked low, CS held low until the consumer takes the byte
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_left    <= r_left - 16'd1;
                        if (r_left == 16'd1) begin
                            spi_cs_n <= 1'b1;
                            r_state  <= S_FINISH;
                        end else begin
                            r_div   <= '0;
                            r_bits  <= '0;
                            r_state <= S_DATA;
                        end
                    end
                end

                S_FINISH: begin
                    spi_cs_n <= 1'b1;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_reader
// Description : Self-checking bench for spi_flash_reader. Two instances
//               (no wake / wake) share a behavioural flash on the pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetq;
    logic [1:0]       start;
    logic [23:0]      addr;
    logic [15:0]      count;
    logic             abort;
    logic             out_ready;
    logic             miso = 1'b0;
    logic [1:0][7:0]  out_data;
    logic [1:0]       out_valid, busy, done, sck, mosi, cs_n;

    spi_flash_reader #(.CLKDIV(2), .WAKE(0), .WAKE_CYCLES(144)) u_dut0 (
        .clk(clk), .resetq(resetq), .start(start[0]), .addr(addr), .count(count),
        .abort(abort), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .busy(busy[0]), .done(done[0]), .spi_sck(sck[0]),
        .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0]), .spi_miso(miso));

    spi_flash_reader #(.CLKDIV(2), .WAKE(1), .WAKE_CYCLES(144)) u_dut1 (
        .clk(clk), .resetq(resetq), .start(start[1]), .addr(addr), .count(count),
        .abort(abort), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .busy(busy[1]), .done(done[1]), .spi_sck(sck[1]),
        .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1]), .spi_miso(miso));

    int n_checks = 0;
    int n_errors = 0;

    // Flash contents as a pure function of address
    function automatic logic [7:0] mem(input logic [23:0] a);
        if (a == 24'h123456) return 8'hA5;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h3C;
    endfunction

    function automatic logic miso_bit(input logic [23:0] base, input int d);
        logic [23:0] a;
        logic [7:0]  b;
        a = base + 24'(d / 8);
        b = mem(a);
        return b[7 - (d % 8)];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- pin-level flash model and monitor ----------------
    int          sel = 0;
    int          cyc = 0;
    logic        p_cs = 1'b1, p_sck = 1'b0;
    logic [31:0] m_cmd = '0;
    int          m_rises = 0, m_high = 0, m_tfall = 0, m_first = 0, m_lastrise = 0, m_maxgap = 0;
    int          ep_rises[$], ep_first[$], ep_maxgap[$], ep_gap[$];
    logic [31:0] ep_cmd[$];
    logic [7:0]  rx_q[$];
    int          done_cnt = 0, viol = 0;

    always @(negedge clk) begin
        logic c, s;
        c = cs_n[sel];
        s = sck[sel];
        cyc++;
        if (out_valid[sel] && out_ready) rx_q.push_back(out_data[sel]);
        if (done[sel]) done_cnt++;
        if (s && (c || out_valid[sel])) viol++;
        if (!c) begin
            if (p_cs) begin
                ep_gap.push_back(m_high);
                m_rises = 0; m_cmd = '0; m_tfall = cyc; m_first = -1; m_maxgap = 0;
            end
            if (s && !p_sck) begin
                if (m_rises < 32) m_cmd = {m_cmd[30:0], mosi[sel]};
                if (m_rises == 0) m_first = cyc - m_tfall;
                else if (cyc - m_lastrise > m_maxgap) m_maxgap = cyc - m_lastrise;
                m_lastrise = cyc;
                m_rises++;
            end
            if (!s) miso = (m_rises >= 32) ? miso_bit(m_cmd[23:0], m_rises - 32) : 1'b0;
        end else begin
            if (!p_cs) begin
                ep_rises.push_back(m_rises); ep_cmd.push_back(m_cmd);
                ep_first.push_back(m_first); ep_maxgap.push_back(m_maxgap);
                m_high = 0;
            end
            m_high++;
        end
        p_cs = c;
        p_sck = s;
    end

    task automatic clear_mon(input int inst);
        sel = inst;
        rx_q.delete(); ep_rises.delete(); ep_first.delete();
        ep_maxgap.delete(); ep_gap.delete(); ep_cmd.delete();
        done_cnt = 0; viol = 0; m_rises = 0;
    endtask

    task automatic check_idle(input int inst, input string tag, input logic with_data);
        check($sformatf("%s_cs_n", tag), 32'(cs_n[inst]), 1);
        check($sformatf("%s_sck", tag), 32'(sck[inst]), 0);
        check($sformatf("%s_mosi", tag), 32'(mosi[inst]), 0);
        check($sformatf("%s_busy", tag), 32'(busy[inst]), 0);
        check($sformatf("%s_done", tag), 32'(done[inst]), 0);
        check($sformatf("%s_valid", tag), 32'(out_valid[inst]), 0);
        if (with_data) check($sformatf("%s_data", tag), 32'(out_data[inst]), 0);
    endtask

    // One full transaction, compared against the reference model
    task automatic run_txn(input int inst, input logic [23:0] a, input logic [15:0] n,
                           input int mode, input int poke, input logic with_abort,
                           input int exp_rises);
        int          t, stall, total, last;
        logic [23:0] ea;
        logic [31:0] w;
        @(posedge clk) #1;
        clear_mon(inst);
        addr = a; count = n; start[inst] = 1'b1; abort = with_abort;
        @(posedge clk) #1;
        start[inst] = 1'b0; abort = 1'b0;
        check("busy_after_start", 32'(busy[inst]), 1);
        t = 0; stall = 0;
        while (!done[inst] && t < 6000) begin
            if (t == poke) begin
                start[inst] = 1'b1; addr = ~a; count = n + 16'd5;
            end else begin
                start[inst] = 1'b0;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid[inst] && rx_q.size() == 1 && stall < 20) begin
                        out_ready = 1'b0; stall++;
                    end else out_ready = 1'b1;
                end
            endcase
            @(posedge clk) #1;
            t++;
        end
        start[inst] = 1'b0; out_ready = 1'b1;
        check("done_seen", 32'(done[inst]), 1);
        check("busy_with_done", 32'(busy[inst]), 0);
        repeat (4) @(posedge clk);
        #1;
        check("byte_count", rx_q.size(), 32'(n));
        for (int k = 0; k < rx_q.size() && k < int'(n); k++) begin
            ea = a + 24'(k);
            check($sformatf("byte%0d", k), 32'(rx_q[k]), 32'(mem(ea)));
        end
        total = 0;
        foreach (ep_rises[k]) total += ep_rises[k];
        check("sck_pulses", total, exp_rises);
        check("done_pulses", done_cnt, 1);
        check("sck_high_in_stall_or_cs_high", viol, 0);
        if (n != 16'd0) begin
            check("cs_episodes", ep_cmd.size(), (inst == 1) ? 2 : 1);
            if (ep_cmd.size() == ((inst == 1) ? 2 : 1)) begin
                last = ep_cmd.size() - 1;
                check("read_cmd", ep_cmd[last], {8'h03, a});
                check("first_rise_delay", ep_first[last], 2);
                if (mode == 0 && n == 16'd1) check("sck_period", ep_maxgap[last], 4);
                if (inst == 1) begin
                    w = ep_cmd[0];
                    check("wake_cmd", 32'(w[7:0]), 32'hAB);
                    check("wake_bits", ep_rises[0], 8);
                    check("wake_gap", ep_gap[1], 144);
                end
            end
        end else begin
            check("cs_episodes", ep_cmd.size(), 0);
        end
    endtask

    typedef struct {
        int          inst;
        logic [23:0] a;
        logic [15:0] n;
        int          mode;
        int          poke;
        logic        sa;
        int          exp_rises;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          t, inst, exp;
        logic [23:0] ra;
        logic [15:0] rn;

        vecs[0] = '{0, 24'h123456, 16'd1, 0, -1, 1'b0, 40};
        vecs[1] = '{1, 24'h123456, 16'd1, 0, -1, 1'b0, 48};
        vecs[2] = '{0, 24'h00ABCD, 16'd3, 2, -1, 1'b0, 56};
        vecs[3] = '{0, 24'h000010, 16'd0, 0, -1, 1'b0, 0};
        vecs[4] = '{0, 24'hFFFFFE, 16'd4, 1, -1, 1'b0, 64};
        vecs[5] = '{1, 24'h7F0001, 16'd2, 1, -1, 1'b0, 56};
        vecs[6] = '{0, 24'h222222, 16'd2, 1, 3, 1'b0, 48};
        vecs[7] = '{0, 24'h345678, 16'd1, 0, -1, 1'b1, 40};

        resetq = 1'b0; start = '0; addr = '0; count = '0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle(0, "reset0", 1'b1);
        check_idle(1, "reset1", 1'b1);
        resetq = 1'b1;

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].inst, vecs[i].a, vecs[i].n, vecs[i].mode,
                    vecs[i].poke, vecs[i].sa, vecs[i].exp_rises);

        for (int i = 0; i < 10; i++) begin
            inst = int'($urandom_range(0, 1));
            ra   = 24'($urandom);
            rn   = 16'($urandom_range(0, 4));
            exp  = (rn == 16'd0) ? 0 : ((inst == 1) ? 8 : 0) + 32 + 8 * int'(rn);
            run_txn(inst, ra, rn, 1, -1, 1'b0, exp);
        end

        // Abort in the middle of the address phase
        @(posedge clk) #1;
        clear_mon(0);
        addr = 24'h0F0F0F; count = 16'd2; start[0] = 1'b1;
        @(posedge clk) #1;
        start[0] = 1'b0;
        t = 0;
        while (!(cs_n[0] == 1'b0 && m_rises >= 20) && t < 2000) begin
            @(posedge clk) #1;
            t++;
        end
        check("abort_reached_addr", 32'(cs_n[0]), 0);
        abort = 1'b1;
        @(posedge clk) #1;
        abort = 1'b0;
        check_idle(0, "abort", 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        run_txn(0, 24'h0F0F0F, 16'd2, 0, -1, 1'b0, 48);

        // Reset in the middle of the first data byte
        @(posedge clk) #1;
        clear_mon(0);
        addr = 24'h000100; count = 16'd2; start[0] = 1'b1;
        @(posedge clk) #1;
        start[0] = 1'b0;
        t = 0;
        while (!(cs_n[0] == 1'b0 && m_rises >= 36) && t < 2000) begin
            @(posedge clk) #1;
            t++;
        end
        check("reset_reached_data", 32'(cs_n[0]), 0);
        resetq = 1'b0;
        @(posedge clk) #1;
        resetq = 1'b1;
        check_idle(0, "midrst", 1'b1);
        run_txn(0, 24'h000100, 16'd2, 0, -1, 1'b0, 48);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
